// File: rtl/mux3b_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux3b_rr_arbiter
// Brief    : Five-source arbiter and capture stage ahead of the 5:1 byte mux.
//            Drives the mux select, registers the selected byte, and presents
//            it via valid/ready with a one-cycle grant pulse to the source.
//            Build option: MUX3B_ARB_FIXED_PRIO_EN selects fixed priority
//            (req[0] highest) instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module mux3b_rr_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        req,
    output logic [2:0]        sel,
    input  logic [DATA_W-1:0] mux_data,
    output logic [4:0]        grant,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    localparam logic [2:0] c_last_rst = 3'd4;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [2:0]        r_sel;
    logic [2:0]        w_sel_nxt;
    logic [2:0]        r_cur;
    logic [2:0]        w_cur_nxt;
    logic [2:0]        r_last;
    logic [2:0]        w_last_nxt;
    logic [4:0]        r_grant;
    logic [4:0]        w_grant_nxt;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] w_out_data_nxt;
    logic              r_out_valid;
    logic              w_out_valid_nxt;

    logic [4:0]        w_cur_oh;
    logic [4:0]        w_pend;
    logic [2:0]        w_win_idle;
    logic [2:0]        w_win_hold;
    logic              w_handshake;

`ifdef MUX3B_ARB_FIXED_PRIO_EN
    function automatic logic [2:0] f_fixed(input logic [4:0] pend);
        logic [2:0] v_win;
        v_win = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pend[i]) v_win = 3'(i);
        end
        return v_win;
    endfunction

    assign w_win_idle = f_fixed(req);
    assign w_win_hold = f_fixed(w_pend);
`else
    // Search starts one past the last serviced source and wraps 4 -> 0.
    function automatic logic [2:0] f_rr(input logic [4:0] pend, input logic [2:0] base);
        logic [2:0] v_win;
        logic       v_hit;
        logic [3:0] v_idx;
        v_win = 3'd0;
        v_hit = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            v_idx = {1'b0, base} + 4'(k);
            if (v_idx >= 4'd5) v_idx = v_idx - 4'd5;
            if (!v_hit && pend[v_idx[2:0]]) begin
                v_win = v_idx[2:0];
                v_hit = 1'b1;
            end
        end
        return v_win;
    endfunction

    assign w_win_idle = f_rr(req, r_last);
    assign w_win_hold = f_rr(w_pend, r_last);
`endif

    assign w_cur_oh    = 5'b00001 << r_cur;
    // The just-serviced source may still hold req high; it is never re-granted back to back.
    assign w_pend      = req & ~w_cur_oh;
    assign w_handshake = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_cur_nxt       = r_cur;
        w_last_nxt      = r_last;
        w_grant_nxt     = 5'b00000;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;

        case (r_state)
            S_IDLE: begin
                w_out_valid_nxt = 1'b0;
                if (|req) begin
                    w_sel_nxt   = w_win_idle;
                    w_cur_nxt   = w_win_idle;
                    w_state_nxt = S_SETTLE;
                end
            end

            S_SETTLE: begin
                w_out_data_nxt  = mux_data;
                w_grant_nxt     = w_cur_oh;
                w_last_nxt      = r_cur;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = S_HOLD;
            end

            S_HOLD: begin
                if (w_handshake) begin
                    w_out_valid_nxt = 1'b0;
                    if (|w_pend) begin
                        w_sel_nxt   = w_win_hold;
                        w_cur_nxt   = w_win_hold;
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_out_valid_nxt = 1'b0;
                w_state_nxt     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sel       <= 3'd0;
            r_cur       <= 3'd0;
            r_last      <= c_last_rst;
            r_grant     <= 5'b00000;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_cur       <= w_cur_nxt;
            r_last      <= w_last_nxt;
            r_grant     <= w_grant_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign sel       = r_sel;
    assign grant     = r_grant;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux3b_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux3b_rr_arbiter
// Brief    : Scoreboard bench for mux3b_rr_arbiter: directed scenarios plus
//            randomized request epochs against a service-order model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux3b_rr_arbiter;

    localparam int DATA_W = 8;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic [4:0]        req       = 5'b00000;
    logic [2:0]        sel;
    logic [DATA_W-1:0] mux_data;
    logic [4:0]        grant;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;

    logic [7:0] src_byte [5];

    typedef struct {
        int       src;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pops   = 0;

    // Stimulus-side mode flags (written only by the driver process)
    bit hold_req   = 1'b0;
    bit rand_ready = 1'b0;
    bit idle_chk   = 1'b0;
    bit lat_chk    = 1'b0;
    bit tput_chk   = 1'b0;
    bit rst_chk    = 1'b0;
    int lat_start  = 0;
    int rst_cyc    = 0;
    int m_last     = 4;

    // Checks computed by the driver are handed to the monitor for tallying
    string       p_name;
    bit          p_ok;
    logic [31:0] p_act;
    logic [31:0] p_exp;
    int          p_cnt  = 0;
    int          p_seen = 0;

    mux3b_rr_arbiter #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .sel       (sel),
        .mux_data  (mux_data),
        .grant     (grant),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always_comb mux_data = (sel < 3'd5) ? src_byte[sel] : 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Winner among a pending set, straight from the arbitration rule.
    function automatic int pick(input int pend, input int last);
`ifdef MUX3B_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) if (((pend >> i) & 1) != 0) return i;
        return (last < 0) ? -1 : -1;
`else
        for (int k = 1; k <= 5; k++) if (((pend >> ((last + k) % 5)) & 1) != 0) return (last + k) % 5;
        return -1;
`endif
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit          prev_v    = 1'b0;
    bit          prev_rdy  = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [2:0]  prev_sel  = 3'd0;
    int          last_g_cyc = -1;
    exp_t        e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (p_cnt != p_seen) begin
            p_seen = p_cnt;
            checks++;
            if (!p_ok) begin
                errors++;
                $display("FAIL %s: actual %0h required %0h (cycle %0d)", p_name, p_act, p_exp, cyc);
            end
        end
        if (!rst_n) begin
            prev_v     = 1'b0;
            prev_rdy   = 1'b0;
            last_g_cyc = -1;
        end else begin
            if (rst_chk && cyc == rst_cyc + 1)
                chk("reset_in_settle", 32'({out_valid, grant, sel}), 32'd0);
            if (idle_chk)
                chk("idle_quiet", 32'({out_valid, grant, sel}), 32'd0);
            if (lat_chk && cyc == lat_start + 1)
                chk("latency_sel", 32'({out_valid, sel}), 32'({1'b0, 3'd2}));
            if (!tput_chk) last_g_cyc = -1;

            if (grant != 5'b00000 || (out_valid && !prev_v)) begin
                chk("capture_valid", 32'(out_valid), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("capture_unexpected_queue", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    chk("grant_onehot", 32'(grant), 32'(1) << e.src);
                    chk("capture_data", 32'(out_data), 32'(e.data));
                    chk("capture_sel", 32'(sel), 32'(e.src));
                end
                if (lat_chk) chk("latency_cycles", 32'(cyc - lat_start), 32'd2);
                if (tput_chk) begin
                    if (last_g_cyc >= 0) chk("throughput_spacing", 32'(cyc - last_g_cyc), 32'd2);
                    last_g_cyc = cyc;
                end
            end else if (prev_v && !prev_rdy) begin
                chk("stall_stable", 32'({out_valid, out_data, sel}), 32'({1'b1, prev_data, prev_sel}));
            end else if (prev_v && prev_rdy) begin
                chk("handshake_drop", 32'(out_valid), 32'd0);
            end

            prev_v    = out_valid;
            prev_rdy  = out_ready;
            prev_data = out_data;
            prev_sel  = sel;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (grant[i]) begin
                if (hold_req) src_byte[i] = src_byte[i] + 8'd1;
                else          req[i]      = 1'b0;
            end
        end
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic post(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        p_name = name;
        p_ok   = ok;
        p_act  = act;
        p_exp  = exp;
        p_cnt++;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 5'b00000;
        tick();
        rst_n  = 1'b1;
        m_last = 4;
    endtask

    task automatic push_epoch(input int mask);
        int pend;
        int s;
        pend = mask;
        while (pend != 0) begin
            s = pick(pend, m_last);
            exp_q.push_back(exp_t'{src: s, data: src_byte[s]});
            pend   = pend & ~(1 << s);
            m_last = s;
        end
    endtask

    task automatic wait_drain(input string name, input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < max) begin
            tick();
            n++;
        end
        if (n >= max) post(name, 1'b0, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] mb [5];
        int prev;
        int s;
        int base;
        int n;

        for (int i = 0; i < 5; i++) src_byte[i] = 8'($urandom);

        // Reset, then quiet request lines
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n    = 1'b1;
        m_last   = 4;
        idle_chk = 1'b1;
        repeat (10) tick();
        idle_chk = 1'b0;

        // Single request: minimum latency
        src_byte[2] = 8'hA5;
        out_ready   = 1'b1;
        exp_q.push_back(exp_t'{src: 2, data: 8'hA5});
        m_last      = 2;
        req         = 5'b00100;
        lat_start   = cyc;
        lat_chk     = 1'b1;
        wait_drain("latency_timeout", 20);
        lat_chk = 1'b0;

        // All sources requesting with req held: service order and throughput
        do_reset();
        hold_req = 1'b1;
        mb       = src_byte;
        prev     = -1;
        for (int k = 0; k < 12; k++) begin
            s = pick(31 & ~((prev < 0) ? 0 : (1 << prev)), m_last);
            exp_q.push_back(exp_t'{src: s, data: mb[s]});
            mb[s]  = mb[s] + 8'd1;
            m_last = s;
            prev   = s;
        end
        base     = pops;
        req      = 5'b11111;
        tput_chk = 1'b1;
        repeat (13) tick();
        tput_chk = 1'b0;
        req      = 5'b00000;
        repeat (5) tick();
        hold_req = 1'b0;
        exp_q.delete();
        post("throughput_grants", (pops - base) >= 6, 32'(pops - base), 32'd6);

        // Stall with out_ready low
        do_reset();
        src_byte[1] = 8'h3C;
        out_ready   = 1'b0;
        exp_q.push_back(exp_t'{src: 1, data: 8'h3C});
        m_last      = 1;
        req         = 5'b00010;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        if (n >= 10) post("stall_capture_timeout", 1'b0, 32'(out_valid), 32'd1);
        repeat (6) tick();
        post("stall_hold_value", (out_data == 8'h3C) && out_valid && (sel == 3'd1),
             32'({out_valid, out_data, sel}), 32'({1'b1, 8'h3C, 3'd1}));
        out_ready = 1'b1;
        tick();
        post("stall_release_drop", !out_valid, 32'(out_valid), 32'd0);
        wait_drain("stall_drain_timeout", 10);

        // Reset asserted during SETTLE discards the capture
        src_byte[2] = 8'h5A;
        req         = 5'b00100;
        tick();
        rst_n   = 1'b0;
        req     = 5'b00000;
        rst_cyc = cyc;
        rst_chk = 1'b1;
        tick();
        rst_n  = 1'b1;
        m_last = 4;
        tick();
        rst_chk = 1'b0;
        for (int i = 0; i < 5; i++) src_byte[i] = 8'($urandom);
        push_epoch(5'b10101);
        req = 5'b10101;
        wait_drain("post_reset_timeout", 40);

        // Randomized request epochs with random backpressure
        rand_ready = 1'b1;
        for (int ep = 0; ep < 40; ep++) begin
            int mask;
            mask = int'($urandom_range(1, 31));
            for (int i = 0; i < 5; i++) src_byte[i] = 8'($urandom);
            push_epoch(mask);
            req = 5'(mask);
            wait_drain("epoch_timeout", 300);
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (4) tick();
        post("final_queue_empty", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
